// File: rtl/radar_pkg.sv
// ----------------------------------------------------------------------------
// radar_pkg
//   Shared types and sizing helpers for the FMCW chirp sequencer.
//   - seq_state_t : frame/chirp scheduler states
//   - DEFAULT_COUNT_W : default width of chirp counters
//   - dwell_width() : width needed for a dwell counter covering every
//                     cycle-count parameter, plus one bit of headroom
//   - DWELL_W : dwell width for the default parameter set
// ----------------------------------------------------------------------------
package radar_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CONFIG,
      SETTLE,
      UP,
      HOLD,
      DOWN,
      GAP
   } seq_state_t;

   localparam int DEFAULT_COUNT_W        = 16;
   localparam int DEFAULT_SETTLE_CYCLES  = 240;
   localparam int DEFAULT_GAP_CYCLES     = 1200;
   localparam int DEFAULT_TIMEOUT_CYCLES = 65535;
   localparam int DEFAULT_HOLD_CYCLES    = 500;

   function automatic int dwell_width(input int settle, input int gap,
                                      input int timeout, input int hold);
      int m;
      m = settle;
      if (gap > m)     m = gap;
      if (timeout > m) m = timeout;
      if (hold > m)    m = hold;
      return $clog2(m) + 1;
   endfunction

   localparam int DWELL_W = dwell_width(DEFAULT_SETTLE_CYCLES, DEFAULT_GAP_CYCLES,
                                        DEFAULT_TIMEOUT_CYCLES, DEFAULT_HOLD_CYCLES);

endpackage

// File: rtl/sync_edge_detect.sv
// ----------------------------------------------------------------------------
// sync_edge_detect
//   Brings an asynchronous status pin into the clk domain through a 2-flop
//   synchroniser and emits a registered 1-cycle pulse on each rising edge.
//   Input-to-pulse latency is 3 clk edges.
// Ports
//   clk        in  clock
//   rst_n      in  async active-low reset
//   async_in   in  asynchronous level input
//   edge_pulse out registered rising-edge pulse
// ----------------------------------------------------------------------------
module sync_edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic edge_pulse
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;
   logic pulse_q;
   logic pulse_d;

   always_comb begin
      pulse_d = sync2_q & ~prev_q;
   end

   // NOTE: flops use non-blocking assignments so every stage samples the
   // pre-edge value of its predecessor; blocking here would collapse the chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         sync1_q <= async_in;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         pulse_q <= pulse_d;
      end
   end

   assign edge_pulse = pulse_q;

endmodule

// File: rtl/radar_chirp_sequencer.sv
// ----------------------------------------------------------------------------
// radar_chirp_sequencer
//   Frame-level scheduler for the FMCW front end. Each frame requests a synth
//   register load, then runs NumChirps chirps (settle, up-ramp, optional
//   top-of-ramp hold, down-ramp, gap). Ramp transitions are keyed on a
//   synchronised rising edge of Synth_DR_Over.
// Build option
//   CHIRP_HOLD_EN : adds a HOLD_CYCLES dwell at the top of each ramp with
//                   Synth_DR_Hold asserted; otherwise Synth_DR_Hold is 0.
// Ports
//   Clk, nReset       clock, async active-low reset
//   Start, Abort      1-cycle frame start / abort requests
//   NumChirps         chirps per frame, latched on accepted Start
//   Cfg_Req/Cfg_Done  synth SPI load handshake
//   Synth_DR_Control  1 = ramp up, 0 = ramp down
//   Synth_DR_Hold     ramp hold
//   Synth_DR_Over     asynchronous ramp-complete flag
//   TxEnable, Acquire PA enable, ADC capture window
//   ChirpIndex        current chirp (0-based), held in IDLE
//   Busy, FrameDone   activity flag, normal-completion pulse
//   Timeout           sticky ramp-timeout error
// All outputs are registered.
// ----------------------------------------------------------------------------
module radar_chirp_sequencer
   import radar_pkg::*;
#(
   parameter int SETTLE_CYCLES  = DEFAULT_SETTLE_CYCLES,
   parameter int GAP_CYCLES     = DEFAULT_GAP_CYCLES,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   parameter int HOLD_CYCLES    = DEFAULT_HOLD_CYCLES,
   parameter int COUNT_W        = DEFAULT_COUNT_W
) (
   input  logic               Clk,
   input  logic               nReset,
   input  logic               Start,
   input  logic               Abort,
   input  logic [COUNT_W-1:0] NumChirps,
   output logic               Cfg_Req,
   input  logic               Cfg_Done,
   output logic               Synth_DR_Control,
   output logic               Synth_DR_Hold,
   input  logic               Synth_DR_Over,
   output logic               TxEnable,
   output logic               Acquire,
   output logic [COUNT_W-1:0] ChirpIndex,
   output logic               Busy,
   output logic               FrameDone,
   output logic               Timeout
);

   localparam int DWELL_BITS = dwell_width(SETTLE_CYCLES, GAP_CYCLES,
                                           TIMEOUT_CYCLES, HOLD_CYCLES);

   // Terminal dwell values: a state lasting N cycles exits when dwell == N-1.
   localparam logic [DWELL_BITS-1:0] SETTLE_LAST  = DWELL_BITS'(SETTLE_CYCLES - 1);
   localparam logic [DWELL_BITS-1:0] GAP_LAST     = DWELL_BITS'(GAP_CYCLES - 1);
   localparam logic [DWELL_BITS-1:0] TIMEOUT_LAST = DWELL_BITS'(TIMEOUT_CYCLES - 1);
`ifdef CHIRP_HOLD_EN
   localparam logic [DWELL_BITS-1:0] HOLD_LAST    = DWELL_BITS'(HOLD_CYCLES - 1);
`endif

   seq_state_t              state_q,      state_d;
   logic [DWELL_BITS-1:0]   dwell_q,      dwell_d;
   logic [COUNT_W-1:0]      num_chirps_q, num_chirps_d;
   logic [COUNT_W-1:0]      chirp_idx_q,  chirp_idx_d;
   logic                    timeout_q,    timeout_d;
   logic                    frame_done_q, frame_done_d;
   logic                    cfg_req_q,    cfg_req_d;
   logic                    dr_control_q, dr_control_d;
   logic                    tx_enable_q,  tx_enable_d;
   logic                    acquire_q,    acquire_d;
   logic                    busy_q,       busy_d;
`ifdef CHIRP_HOLD_EN
   logic                    dr_hold_q,    dr_hold_d;
`endif

   logic over_edge;
   logic last_chirp;

   sync_edge_detect u_over_sync (
      .clk        (Clk),
      .rst_n      (nReset),
      .async_in   (Synth_DR_Over),
      .edge_pulse (over_edge)
   );

   // ---------------------------------------------------------------------
   // Next-state, counters and output decode
   // ---------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path
      // through this block leaves a value unassigned and no latch is inferred.
      state_d      = state_q;
      dwell_d      = dwell_q + DWELL_BITS'(1);
      num_chirps_d = num_chirps_q;
      chirp_idx_d  = chirp_idx_q;
      timeout_d    = timeout_q;
      frame_done_d = 1'b0;
      last_chirp   = (chirp_idx_q == num_chirps_q - COUNT_W'(1));

      // Abort wins over everything, including Start and a coincident OverEdge.
      if (Abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (Start && (NumChirps != '0)) begin
                  state_d      = CONFIG;
                  num_chirps_d = NumChirps;
                  chirp_idx_d  = '0;
                  timeout_d    = 1'b0;
               end
            end
            CONFIG: begin
               if (Cfg_Done) state_d = SETTLE;
            end
            SETTLE: begin
               if (dwell_q == SETTLE_LAST) state_d = UP;
            end
            UP: begin
               if (over_edge) begin
`ifdef CHIRP_HOLD_EN
                  state_d = HOLD;
`else
                  state_d = DOWN;
`endif
               end else if (dwell_q == TIMEOUT_LAST) begin
                  state_d   = IDLE;
                  timeout_d = 1'b1;
               end
            end
`ifdef CHIRP_HOLD_EN
            HOLD: begin
               if (dwell_q == HOLD_LAST) state_d = DOWN;
            end
`endif
            DOWN: begin
               if (over_edge) begin
                  state_d = GAP;
               end else if (dwell_q == TIMEOUT_LAST) begin
                  state_d   = IDLE;
                  timeout_d = 1'b1;
               end
            end
            GAP: begin
               if (dwell_q == GAP_LAST) begin
                  if (last_chirp) begin
                     state_d      = IDLE;
                     frame_done_d = 1'b1;
                  end else begin
                     state_d     = SETTLE;
                     chirp_idx_d = chirp_idx_q + COUNT_W'(1);
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // Dwell restarts on every state entry and idles at zero.
      if ((state_d != state_q) || (state_q == IDLE)) dwell_d = '0;

      // NOTE: strobes are decoded from the next state and registered, so each
      // output flop lines up with the state register instead of lagging it.
      cfg_req_d    = 1'b0;
      dr_control_d = 1'b0;
      tx_enable_d  = 1'b0;
      acquire_d    = 1'b0;
      busy_d       = (state_d != IDLE);
`ifdef CHIRP_HOLD_EN
      dr_hold_d    = 1'b0;
`endif
      case (state_d)
         CONFIG: cfg_req_d = 1'b1;
         SETTLE: tx_enable_d = 1'b1;
         UP: begin
            dr_control_d = 1'b1;
            tx_enable_d  = 1'b1;
            acquire_d    = 1'b1;
         end
`ifdef CHIRP_HOLD_EN
         HOLD: begin
            dr_hold_d    = 1'b1;
            dr_control_d = 1'b1;
            tx_enable_d  = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------------
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state_q      <= IDLE;
         dwell_q      <= '0;
         num_chirps_q <= '0;
         chirp_idx_q  <= '0;
         timeout_q    <= 1'b0;
         frame_done_q <= 1'b0;
         cfg_req_q    <= 1'b0;
         dr_control_q <= 1'b0;
         tx_enable_q  <= 1'b0;
         acquire_q    <= 1'b0;
         busy_q       <= 1'b0;
`ifdef CHIRP_HOLD_EN
         dr_hold_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         dwell_q      <= dwell_d;
         num_chirps_q <= num_chirps_d;
         chirp_idx_q  <= chirp_idx_d;
         timeout_q    <= timeout_d;
         frame_done_q <= frame_done_d;
         cfg_req_q    <= cfg_req_d;
         dr_control_q <= dr_control_d;
         tx_enable_q  <= tx_enable_d;
         acquire_q    <= acquire_d;
         busy_q       <= busy_d;
`ifdef CHIRP_HOLD_EN
         dr_hold_q    <= dr_hold_d;
`endif
      end
   end

   assign Cfg_Req          = cfg_req_q;
   assign Synth_DR_Control = dr_control_q;
   assign TxEnable         = tx_enable_q;
   assign Acquire          = acquire_q;
   assign ChirpIndex       = chirp_idx_q;
   assign Busy             = busy_q;
   assign FrameDone        = frame_done_q;
   assign Timeout          = timeout_q;
`ifdef CHIRP_HOLD_EN
   assign Synth_DR_Hold    = dr_hold_q;
`else
   assign Synth_DR_Hold    = 1'b0;
`endif

endmodule
